// File: rtl/zym_scan_pkg.sv
// Shared types and constants for the segment scanner.
// The optional decimal-point path is enabled with the ZYM_SCAN_DP_EN macro.
package zym_scan_pkg;

    localparam int SEG_W        = 7;
    localparam int DEAD_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

endpackage

// File: rtl/zym_scan_pwm.sv
// 3-bit brightness phase counter; lit reports whether the upcoming cycle is in the lit phase.
module zym_scan_pwm (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       run,
    input  logic [2:0] bright,
    output logic       lit
);

    logic [2:0] ph_q;
    logic [2:0] ph_d;

    always_comb begin
        ph_d = ph_q;
        if (clr) begin
            ph_d = 3'd0;
        end else if (run) begin
            ph_d = ph_q + 3'd1;
        end
    end

    // Compared against the next phase so the registered outputs line up with it.
    assign lit = (ph_d <= bright);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ph_q <= 3'd0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/zym_seg_scanner.sv
// Time-multiplexed 7-segment scanner with dwell, dead-time blanking and brightness PWM.
// Defining ZYM_SCAN_DP_EN adds the dp_in / dp_out decimal-point path.
module zym_seg_scanner
    import zym_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_W    = 9,
    parameter int DEAD_CYC   = DEAD_CYC_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_DIGITS*SEG_W-1:0] dig_in,
    input  logic [DWELL_W-1:0]          dwell,
    input  logic [2:0]                  bright,
`ifdef ZYM_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]       dp_in,
    output logic                        dp_out,
`endif
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_done
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYC + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

    scan_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [DEAD_W-1:0]       dead_cnt_q, dead_cnt_d;
    logic [SEG_W-1:0]        seg_hold_q, seg_hold_d;
    logic [SEG_W-1:0]        seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   an_out_q, an_out_d;
    logic                    frame_done_q, frame_done_d;
    logic                    pwm_clr, pwm_run, pwm_lit;

    zym_scan_pwm u_pwm (
        .clock  (clock),
        .reset  (reset),
        .clr    (pwm_clr),
        .run    (pwm_run),
        .bright (bright),
        .lit    (pwm_lit)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        dead_cnt_d   = dead_cnt_q;
        seg_hold_d   = seg_hold_q;
        frame_done_d = 1'b0;
        pwm_clr      = 1'b0;
        pwm_run      = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                seg_hold_d  = dig_in[int'(idx_q)*SEG_W +: SEG_W];
                dwell_cnt_d = '0;
                pwm_clr     = 1'b1;
                state_d     = SHOW;
            end
            SHOW: begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
                pwm_run     = 1'b1;
                if (dwell_cnt_q == dwell) begin
                    state_d    = BLANK;
                    dead_cnt_d = '0;
                end
            end
            BLANK: begin
                dead_cnt_d = dead_cnt_q + 1'b1;
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d      = LOAD;
                    idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    frame_done_d = (idx_q == LAST_IDX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping en abandons the frame wherever it is.
        if (!en) begin
            state_d      = IDLE;
            idx_d        = '0;
            frame_done_d = 1'b0;
        end

        an_out_d  = (state_d == SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_out_d = (state_d == SHOW && pwm_lit) ? seg_hold_d : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dwell_cnt_q  <= '0;
            dead_cnt_q   <= '0;
            seg_hold_q   <= '0;
            seg_out_q    <= '0;
            an_out_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            seg_hold_q   <= seg_hold_d;
            seg_out_q    <= seg_out_d;
            an_out_q     <= an_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign an_out     = an_out_q;
    assign frame_done = frame_done_q;

`ifdef ZYM_SCAN_DP_EN
    logic dp_hold_q, dp_hold_d;
    logic dp_out_q, dp_out_d;

    always_comb begin
        dp_hold_d = (state_q == LOAD) ? dp_in[idx_q] : dp_hold_q;
        dp_out_d  = (state_d == SHOW && pwm_lit) ? dp_hold_d : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dp_hold_q <= 1'b0;
            dp_out_q  <= 1'b0;
        end else begin
            dp_hold_q <= dp_hold_d;
            dp_out_q  <= dp_out_d;
        end
    end

    assign dp_out = dp_out_q;
`endif

endmodule

// File: tb/tb_zym_seg_scanner.sv
// Self-checking bench for zym_seg_scanner: every output cycle is compared against
// an expectation built from the scan timing rules (LOAD, dwell+1 SHOW, DEAD_CYC BLANK).
module tb_zym_seg_scanner;

    localparam int ND   = 4;
    localparam int DW   = 9;
    localparam int DEAD = 2;
    localparam int W    = 13;  // {frame_done, an_out[3:0], seg_out[6:0], dp}

    logic          clock;
    logic          reset;
    logic          en;
    logic [ND*7-1:0] dig_in;
    logic [DW-1:0] dwell;
    logic [2:0]    bright;
    logic [6:0]    seg_out;
    logic [ND-1:0] an_out;
    logic          frame_done;
    logic [ND-1:0] dp_in;
    logic          dp_obs;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    zym_seg_scanner #(
        .NUM_DIGITS (ND),
        .DWELL_W    (DW),
        .DEAD_CYC   (DEAD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .dig_in     (dig_in),
        .dwell      (dwell),
        .bright     (bright),
`ifdef ZYM_SCAN_DP_EN
        .dp_in      (dp_in),
        .dp_out     (dp_obs),
`endif
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

`ifndef ZYM_SCAN_DP_EN
    assign dp_obs = 1'b0;
`endif

    function automatic logic [W-1:0] pack(input logic fd, input logic [ND-1:0] an,
                                          input logic [6:0] seg, input logic dp);
        return {fd, an, seg, dp};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got fd=%b an=%b seg=%h dp=%b, want fd=%b an=%b seg=%h dp=%b",
                     tag, obs[12], obs[11:8], obs[7:1], obs[0],
                     expv[12], expv[11:8], expv[7:1], expv[0]);
        end
    endtask

    // Push the expectation for the coming cycle, clock once, then pop and compare.
    task automatic chk_cycle(input string tag, input logic [W-1:0] expv);
        logic [W-1:0] e;
        exp_q.push_back(expv);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check(tag, pack(frame_done, an_out, seg_out, dp_obs), e);
    endtask

    // One digit visit: LOAD, dwell+1 SHOW cycles, DEAD blank cycles.
    // stop_after>0 ends the visit after that many cycles; chg_at>=0 rewrites
    // digit 0 right after SHOW cycle chg_at has been observed.
    task automatic play_digit(input int d, input bit fd, input int stop_after,
                              input int chg_at, input logic [6:0] chg_val);
        logic [6:0] seg;
        logic       dpb;
        logic       lit;
        int         n;
        seg = dig_in[d*7 +: 7];
`ifdef ZYM_SCAN_DP_EN
        dpb = dp_in[d];
`else
        dpb = 1'b0;
`endif
        n = 0;
        chk_cycle("load", pack(fd, '0, '0, 1'b0));
        n++;
        if (n == stop_after) return;
        for (int k = 0; k <= int'(dwell); k++) begin
            lit = ((k % 8) <= int'(bright));
            chk_cycle("show", pack(1'b0, ND'(1) << d, lit ? seg : 7'h00, lit & dpb));
            if (k == chg_at) dig_in[6:0] = chg_val;
            n++;
            if (n == stop_after) return;
        end
        for (int b = 0; b < DEAD; b++) begin
            chk_cycle("blank", pack(1'b0, '0, '0, 1'b0));
            n++;
            if (n == stop_after) return;
        end
    endtask

    task automatic play_frame(input bit fd_first);
        for (int d = 0; d < ND; d++) begin
            play_digit(d, (d == 0) ? fd_first : 1'b0, 0, -1, 7'h00);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        en       = 1'b1;
        dig_in   = {7'h06, 7'h5B, 7'h4F, 7'h66};
        dwell    = 9'd3;
        bright   = 3'd7;
        dp_in    = 4'b0000;

        // Reset held two cycles with en high: everything quiet.
        chk_cycle("rst0", pack(1'b0, '0, '0, 1'b0));
        chk_cycle("rst1", pack(1'b0, '0, '0, 1'b0));
        reset = 1'b1;

        // Full brightness, two frames; frame_done only after a completed frame.
        play_frame(1'b0);
        play_frame(1'b1);

        // PWM duty 2/8 over a 16-cycle dwell.
        bright = 3'd1;
        dwell  = 9'd15;
        play_frame(1'b1);

        // Snapshot: digit 0 rewritten during its 2nd SHOW cycle.
        bright = 3'd7;
        dwell  = 9'd3;
        dig_in[6:0] = 7'h3F;
        play_digit(0, 1'b1, 0, 0, 7'h06);
        for (int d = 1; d < ND; d++) play_digit(d, 1'b0, 0, -1, 7'h00);
        play_digit(0, 1'b1, 0, -1, 7'h00);

        // Drop en in digit 2 SHOW, then re-enable from digit 0.
        play_digit(1, 1'b0, 0, -1, 7'h00);
        play_digit(2, 1'b0, 3, -1, 7'h00);
        en = 1'b0;
        chk_cycle("dis0", pack(1'b0, '0, '0, 1'b0));
        chk_cycle("dis1", pack(1'b0, '0, '0, 1'b0));
        en = 1'b1;
        play_frame(1'b0);

        // Reset during the last digit's BLANK: no frame_done, restart at digit 0.
        play_frame(1'b1);
        play_digit(0, 1'b1, 0, -1, 7'h00);
        play_digit(1, 1'b0, 0, -1, 7'h00);
        play_digit(2, 1'b0, 0, -1, 7'h00);
        play_digit(3, 1'b0, 6, -1, 7'h00);
        reset = 1'b0;
        chk_cycle("rstmid", pack(1'b0, '0, '0, 1'b0));
        reset = 1'b1;
        play_frame(1'b0);

        // dwell=0: single-cycle SHOW, decimal point only on digit 2.
        dwell = 9'd0;
        dp_in = 4'b0100;
        play_frame(1'b1);
        play_frame(1'b1);
        chk_cycle("tail", pack(1'b1, '0, '0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
